booth_mult_scheduler: RTL and testbench

Shares one sequential radix-4 Booth multiplier core (`Radix4BoothMultiplierSeq`, 32x32 -> 64-bit signed) among N requesters. It selects requests round-robin and sequences the core's `rst`/`load` pins for each operation. It holds the operands stable for the whole run, captures the 64-bit product and returns it with the requester ID on one shared response channel. It sits between the client ports and the core instance, so clients never drive the core directly.

---
 rtl/booth_sched_pkg.sv | 17 +
 rtl/booth_mult_scheduler_rr_arbiter.sv | 34 +++
 rtl/booth_mult_scheduler.sv | 152 +++++++++++++++
 tb/tb_booth_mult_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_sched_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier scheduler.
package booth_sched_pkg;

    localparam int OPND_W         = 32;
    localparam int PROD_W         = 64;
    localparam int DEF_RUN_CYCLES = 48;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_CAPT = 3'd4,
        S_RESP = 3'd5
    } sched_state_t;

endpackage

// File: rtl/booth_mult_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr_i, wrapping. The pointer register is owned by the caller.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_req_o
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // Scan N positions starting at the pointer and keep the first hit.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_req_o = |req_i;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDX_W'((int'(ptr_i) + k) % N);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/booth_mult_scheduler.sv
// Shares one sequential radix-4 Booth multiplier core among N_REQ requesters.
// Each operation: accept (IDLE) -> core reset (CLR) -> core load (LOAD) ->
// RUN_CYCLES of compute (RUN) -> product capture (CAPT) -> response (RESP).
//
// Handshakes: a request transfers in the cycle where i_req_valid[k] and
// o_req_ready[k] are both high; o_req_ready is a combinational one-hot strobe
// raised only in IDLE. A response transfers in the cycle where o_resp_valid
// and i_resp_ready are both high; id and product stay stable until then.
module booth_mult_scheduler
    import booth_sched_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int RUN_CYCLES = DEF_RUN_CYCLES,
    parameter int ID_W       = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        i_req_valid,
    output logic [N_REQ-1:0]        o_req_ready,
    input  logic [N_REQ*OPND_W-1:0] i_req_a,
    input  logic [N_REQ*OPND_W-1:0] i_req_b,
    output logic                    o_resp_valid,
    input  logic                    i_resp_ready,
    output logic [ID_W-1:0]         o_resp_id,
    output logic [PROD_W-1:0]       o_resp_product,
    output logic                    o_busy,
    output logic                    o_core_rst,
    output logic                    o_core_load,
    output logic [OPND_W-1:0]       o_core_a,
    output logic [OPND_W-1:0]       o_core_b,
    input  logic [PROD_W-1:0]       i_core_product,
    output logic [2:0]              o_dbg_state
);

    localparam int CNT_W = $clog2(RUN_CYCLES + 1);

    sched_state_t      state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
    logic [OPND_W-1:0] a_q, a_d;
    logic [OPND_W-1:0] b_q, b_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [PROD_W-1:0] prod_q, prod_d;

    logic [N_REQ-1:0]  gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic              any_req;
    logic [N_REQ-1:0]  req_ready;
    logic              core_rst;
    logic              core_load;
    logic              resp_valid;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req_i     (i_req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_req_o (any_req)
    );

    // Next-state, datapath updates and core pin sequencing.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        run_cnt_d  = run_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        prod_d     = prod_q;
        req_ready  = '0;
        core_rst   = 1'b0;
        core_load  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    req_ready = gnt;
                    a_d       = i_req_a[int'(gnt_idx)*OPND_W +: OPND_W];
                    b_d       = i_req_b[int'(gnt_idx)*OPND_W +: OPND_W];
                    id_d      = gnt_idx;
                    rr_ptr_d  = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + ID_W'(1);
                    state_d   = S_CLR;
                end
            end
            S_CLR: begin
                // The core keeps its accumulator and step counters until reset.
                core_rst = 1'b1;
                state_d  = S_LOAD;
            end
            S_LOAD: begin
                core_load = 1'b1;
                run_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                run_cnt_d = run_cnt_q + CNT_W'(1);
                if (run_cnt_q == CNT_W'(RUN_CYCLES - 1)) begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                prod_d  = i_core_product;
                state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (i_resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            run_cnt_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            prod_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            run_cnt_q <= run_cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            id_q      <= id_d;
            prod_q    <= prod_d;
        end
    end

    // Operands come straight from the latched registers so the core sees
    // stable pins for the whole run, whatever the requester does meanwhile.
    assign o_req_ready    = rst ? '0 : req_ready;
    assign o_core_rst     = core_rst | rst;
    assign o_core_load    = core_load;
    assign o_core_a       = a_q;
    assign o_core_b       = b_q;
    assign o_resp_valid   = resp_valid;
    assign o_resp_id      = id_q;
    assign o_resp_product = prod_q;
    assign o_busy         = (state_q != S_IDLE);
    assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Directed bench for booth_mult_scheduler with a behavioural multiplier core.
module tb_booth_mult_scheduler;

  localparam int N    = 4;
  localparam int ID_W = 2;
  localparam int RC   = 48;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [31:0]     ra [N];
  logic [31:0]     rb [N];
  logic [N*32-1:0] req_a_bus, req_b_bus;
  logic            resp_valid, resp_ready;
  logic [ID_W-1:0] resp_id;
  logic [63:0]     resp_prod;
  logic            busy, core_rst, core_load;
  logic [31:0]     core_a, core_b;
  logic [63:0]     core_prod;
  logic [2:0]      dbg_state;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_a_bus[g*32 +: 32] = ra[g];
    assign req_b_bus[g*32 +: 32] = rb[g];
  end

  booth_mult_scheduler #(.N_REQ(N), .RUN_CYCLES(RC), .ID_W(ID_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_a        (req_a_bus),
    .i_req_b        (req_b_bus),
    .o_resp_valid   (resp_valid),
    .i_resp_ready   (resp_ready),
    .o_resp_id      (resp_id),
    .o_resp_product (resp_prod),
    .o_busy         (busy),
    .o_core_rst     (core_rst),
    .o_core_load    (core_load),
    .o_core_a       (core_a),
    .o_core_b       (core_b),
    .i_core_product (core_prod),
    .o_dbg_state    (dbg_state)
  );

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y;
    x = {{32{a[31]}}, a};
    y = {{32{b[31]}}, b};
    return x * y;
  endfunction

  // ---------------- behavioural core ----------------
  // Product appears only RC cycles after load, multiplier read from the pin.
  logic [31:0] core_a_l;
  int          core_cnt = 0;
  logic        core_loaded = 1'b0;
  always @(posedge clk) begin
    if (core_rst) begin
      core_cnt    <= 0;
      core_loaded <= 1'b0;
    end else if (core_load) begin
      core_a_l    <= core_a;
      core_cnt    <= 0;
      core_loaded <= 1'b1;
    end else if (core_loaded && core_cnt < 1000) begin
      core_cnt <= core_cnt + 1;
    end
  end
  assign core_prod = (core_loaded && core_cnt >= RC) ? smul(core_a_l, core_b)
                                                     : 64'hBADB_AD00_BADB_AD00;

  // ---------------- scoreboard ----------------
  logic [ID_W+63:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_accept(input int exp_idx, input bit push, input logic [63:0] exp_prod,
                             output int t_acc);
    int n;
    bit seen;
    logic [N-1:0] onehot;
    n = 0; seen = 1'b0; t_acc = -1;
    while (!seen && n < 300) begin
      #1;
      if (req_ready != '0) begin
        seen  = 1'b1;
        t_acc = cyc;
      end else begin
        tick();
        n++;
      end
    end
    chk("accept_seen", 64'(seen), 64'd1);
    if (seen) begin
      onehot = '0;
      onehot[exp_idx] = 1'b1;
      chk("grant", 64'(req_ready), 64'(onehot));
      if (push) exp_q.push_back({ID_W'(exp_idx), exp_prod});
    end
  endtask

  task automatic follow_op(input int t_acc, input int k, input logic [N-1:0] drop, input bit chg_b);
    logic [31:0] a0, b0;
    int off;
    bit ok_rst, ok_load, ok_opnd, ok_rdy, ok_busy;
    a0 = ra[k]; b0 = rb[k];
    ok_rst = 1; ok_load = 1; ok_opnd = 1; ok_rdy = 1; ok_busy = 1;
    off = 0;
    while (resp_valid !== 1'b1 && off < 80) begin
      tick();
      if (off == 0) begin
        req_valid = req_valid & ~drop;
        if (chg_b) rb[k] = ~rb[k];
      end
      #1;
      off = cyc - t_acc;
      if (resp_valid !== 1'b1) begin
        if (core_rst !== (off == 1)) ok_rst = 0;
        if (core_load !== (off == 2)) ok_load = 0;
        if (core_a !== a0 || core_b !== b0) ok_opnd = 0;
        if (req_ready !== '0) ok_rdy = 0;
        if (busy !== 1'b1) ok_busy = 0;
      end
    end
    chk("resp_latency", 64'(off), 64'(RC + 4));
    chk("core_rst_pulse", 64'(ok_rst), 64'd1);
    chk("core_load_pulse", 64'(ok_load), 64'd1);
    chk("operand_hold", 64'(ok_opnd), 64'd1);
    chk("no_ready_busy", 64'(ok_rdy), 64'd1);
    chk("busy_window", 64'(ok_busy), 64'd1);
  endtask

  task automatic take_resp(input int hold);
    logic [ID_W+63:0] e;
    logic [ID_W-1:0]  id0;
    logic [63:0]      p0;
    bit ok;
    chk("sb_depth", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("resp_id", 64'(resp_id), 64'(e[64 +: ID_W]));
      chk("resp_prod", resp_prod, e[63:0]);
    end
    id0 = resp_id; p0 = resp_prod; ok = 1;
    for (int i = 0; i < hold; i++) begin
      tick(); #1;
      if (resp_valid !== 1'b1 || resp_id !== id0 || resp_prod !== p0 || req_ready !== '0) ok = 0;
    end
    if (hold > 0) chk("backpressure_hold", 64'(ok), 64'd1);
    resp_ready = 1'b1;
    tick(); #1;
    chk("back_to_idle", 64'(busy), 64'd0);
    chk("resp_dropped", 64'(resp_valid), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t, t_prev;
    bit ok;
    rst = 1'b1; req_valid = '0; resp_ready = 1'b1;
    for (int k = 0; k < N; k++) begin ra[k] = '0; rb[k] = '0; end
    tick(); tick(); #1;
    chk("core_rst_in_reset", 64'(core_rst), 64'd1);
    chk("ready_in_reset", 64'(req_ready), 64'd0);
    tick();
    rst = 1'b0; #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    chk("rst_resp_prod", resp_prod, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_core_load", 64'(core_load), 64'd0);
    chk("rst_core_ab", {core_a, core_b}, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);

    // single request
    ra[0] = 32'd3; rb[0] = 32'd5; req_valid = 4'b0001;
    wait_accept(0, 1'b1, 64'd15, t);
    follow_op(t, 0, 4'b0001, 1'b0);
    take_resp(0);

    // signed operands
    ra[2] = 32'hFFFF_FFF9; rb[2] = 32'd6; req_valid = 4'b0100;
    wait_accept(2, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, t);
    follow_op(t, 2, 4'b0100, 1'b0);
    take_resp(0);

    // back-pressure; requester 0 waits during the hold and must not be accepted
    ra[3] = 32'd100; rb[3] = 32'hFFFF_FFFD; req_valid = 4'b1000;
    resp_ready = 1'b0;
    wait_accept(3, 1'b1, 64'hFFFF_FFFF_FFFF_FED4, t);
    ra[0] = 32'd1000; rb[0] = 32'd7;
    ra[1] = 32'h8765_4321; rb[1] = 32'd3;
    ra[2] = 32'h0001_0000; rb[2] = 32'h0001_0000;
    follow_op(t, 3, 4'b1000, 1'b0);
    req_valid[0] = 1'b1;
    take_resp(20);

    // round-robin fairness: all requesters stay valid
    ra[3] = 32'hFFFF_FF00; rb[3] = 32'hFFFF_FF00;
    req_valid = 4'b1111;
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_accept(i % N, 1'b1, smul(ra[i % N], rb[i % N]), t);
      if (i > 0) chk("rr_spacing", 64'(t - t_prev), 64'(RC + 5));
      t_prev = t;
      follow_op(t, i % N, (i == 4) ? 4'b1111 : 4'b0000, 1'b0);
      take_resp(0);
    end

    // operand stability: requester 1 flips its multiplier after acceptance
    ra[1] = 32'd12345; rb[1] = 32'd678; req_valid = 4'b0010;
    wait_accept(1, 1'b1, 64'd8369910, t);
    follow_op(t, 1, 4'b0010, 1'b1);
    take_resp(0);

    // reset mid-RUN
    ra[2] = 32'd11; rb[2] = 32'd13; req_valid = 4'b0100;
    wait_accept(2, 1'b0, 64'd0, t);
    tick(); req_valid = '0;
    while (cyc < t + 30) tick();
    rst = 1'b1; #1;
    chk("midrun_core_rst", 64'(core_rst), 64'd1);
    tick(); rst = 1'b0; #1;
    chk("mr_ready", 64'(req_ready), 64'd0);
    chk("mr_resp_valid", 64'(resp_valid), 64'd0);
    chk("mr_resp_id", 64'(resp_id), 64'd0);
    chk("mr_resp_prod", resp_prod, 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_core_load", 64'(core_load), 64'd0);
    chk("mr_core_ab", {core_a, core_b}, 64'd0);
    ok = 1;
    for (int i = 0; i < 60; i++) begin
      tick(); #1;
      if (resp_valid !== 1'b0 || busy !== 1'b0) ok = 0;
    end
    chk("dropped_op_silent", 64'(ok), 64'd1);

    // pointer must be back at 0: requester 1 wins over requester 3
    ra[1] = 32'h7FFF_FFFF; rb[1] = 32'd2;
    ra[3] = 32'd9; rb[3] = 32'hFFFF_FFFF;
    req_valid = 4'b1010;
    wait_accept(1, 1'b1, 64'h0000_0000_FFFF_FFFE, t);
    follow_op(t, 1, 4'b0010, 1'b0);
    take_resp(0);
    wait_accept(3, 1'b1, 64'hFFFF_FFFF_FFFF_FFF7, t);
    follow_op(t, 3, 4'b1000, 1'b0);
    take_resp(0);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
